// File: rtl/branch_pkg.sv
// Shared opcodes, condition codes and flag types
// for the EX-stage branch resolve unit.
package branch_pkg;

  localparam logic [5:0] OP_ADDI  = 6'b100100;
  localparam logic [5:0] OP_ADDS  = 6'b101010;
  localparam logic [5:0] OP_B     = 6'b000101;
  localparam logic [5:0] OP_BCOND = 6'b010101;
  localparam logic [5:0] OP_CBZ   = 6'b101101;
  localparam logic [5:0] OP_LDST  = 6'b111110;
  localparam logic [5:0] OP_SUBS  = 6'b111010;
  localparam logic [5:0] OP_SHIFT = 6'b110100;
  localparam logic [5:0] OP_MUL   = 6'b100110;

  typedef enum logic [4:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Codes 16..31 are undefined and never taken
  function automatic logic cond_eval(cond_e cc, nzcv_t f);
    logic r;
    r = 1'b0;
    case (cc)
      EQ: r = f.z;
      NE: r = !f.z;
      HS: r = f.c;
      LO: r = !f.c;
      MI: r = f.n;
      PL: r = !f.n;
      VS: r = f.v;
      VC: r = !f.v;
      HI: r = f.c & !f.z;
      LS: r = !f.c | f.z;
      GE: r = (f.n == f.v);
      LT: r = (f.n != f.v);
      GT: r = !f.z & (f.n == f.v);
      LE: r = f.z | (f.n != f.v);
      AL: r = 1'b1;
      NV: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-side bundle of the branch resolve unit:
// IF lookup, EX resolve inputs, decode and status outputs.
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              stall;
  logic [ADDR_W-1:0] if_pc;
  logic              if_pred;
  logic              ex_valid;
  logic [31:0]       ex_instr;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_pred;
  logic              ex_rt_zero;
  logic [3:0]        alu_nzcv;
  logic              reg2loc;
  logic              uncond_br;
  logic              br_taken;
  logic              mispredict;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  mp_cnt;

  modport master (
    output stall, if_pc, ex_valid, ex_instr, ex_pc,
    output ex_pred, ex_rt_zero, alu_nzcv,
    input  if_pred, reg2loc, uncond_br, br_taken,
    input  mispredict, flags_q, br_cnt, mp_cnt
  );

  modport slave (
    input  stall, if_pc, ex_valid, ex_instr, ex_pc,
    input  ex_pred, ex_rt_zero, alu_nzcv,
    output if_pred, reg2loc, uncond_br, br_taken,
    output mispredict, flags_q, br_cnt, mp_cnt
  );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters,
// combinational read, synchronous update.
module bht_2bit #(
  parameter int BHT_N  = 16,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_pred,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken
);
  localparam int IDX_W = $clog2(BHT_N);

  logic [1:0]       bht [BHT_N];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       cur;

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign wr_idx  = upd_pc[IDX_W+1:2];
  assign rd_pred = bht[rd_idx][1];
  assign cur     = bht[wr_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (upd_en) begin
      if (upd_taken && cur != 2'b11) begin
        bht[wr_idx] <= cur + 2'b01;
      end else if (!upd_taken && cur != 2'b00) begin
        bht[wr_idx] <= cur - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch decode/resolve with NZCV flags,
// BHT prediction and saturating perf counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int BHT_N  = 16,
  parameter int CNT_W  = 32
) (
  input logic                clk,
  input logic                reset,
  branch_resolve_unit_if.slave bus
);
  logic [5:0]       op;
  logic             is_b;
  logic             is_bcond;
  logic             is_cbz;
  logic             is_fset;
  logic             is_br;
  logic             upd;
  logic             taken;
  logic             mp;
  logic             pred;
  nzcv_t            flags;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;

  assign op       = bus.ex_instr[31:26];
  assign is_b     = (op == OP_B);
  assign is_bcond = (op == OP_BCOND);
  assign is_cbz   = (op == OP_CBZ);
  assign is_fset  = (op == OP_ADDS) || (op == OP_SUBS);
  assign is_br    = is_b | is_bcond | is_cbz;
  assign upd      = bus.ex_valid & !bus.stall;

  always_comb begin
    taken = 1'b0;
    if (bus.ex_valid) begin
      unique case (1'b1)
        is_b:     taken = 1'b1;
        is_cbz:   taken = bus.ex_rt_zero;
        is_bcond: taken = cond_eval(cond_e'(bus.ex_instr[4:0]), flags);
        default:  taken = 1'b0;
      endcase
    end
  end

  assign mp = bus.ex_valid & is_br & (taken != bus.ex_pred);

  assign bus.reg2loc    = (op == OP_ADDS) | (op == OP_SUBS) | (op == OP_MUL);
  assign bus.uncond_br  = is_b;
  assign bus.br_taken   = taken;
  assign bus.mispredict = mp;
  assign bus.flags_q    = flags;
  assign bus.br_cnt     = br_q;
  assign bus.mp_cnt     = mp_q;
  assign bus.if_pred    = pred;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
      br_q  <= '0;
      mp_q  <= '0;
    end else if (upd) begin
      if (is_fset) begin
        flags <= nzcv_t'(bus.alu_nzcv);
      end
      if (is_br && br_q != '1) begin
        br_q <= br_q + 1'b1;
      end
      if (is_br && mp && mp_q != '1) begin
        mp_q <= mp_q + 1'b1;
      end
    end
  end

  // B is always taken, so it would only pollute the BHT
  bht_2bit #(
    .BHT_N (BHT_N),
    .ADDR_W(ADDR_W)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_pc    (bus.if_pc),
    .rd_pred  (pred),
    .upd_en   (upd & (is_bcond | is_cbz)),
    .upd_pc   (bus.ex_pc),
    .upd_taken(taken)
  );

endmodule
